// File: rtl/instr_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_mem_loader: packs a big-endian byte stream into 32-bit words    |
// | and writes them to instruction memory while the core is held.         |
// | Optional XOR checksum byte when LOADER_CHECKSUM_EN is defined.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module instr_mem_loader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              core_hold,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ASSEMBLE = 3'd1,
    S_WRITE    = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK    = 3'd4,
`endif
    S_DONE     = 3'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    index_q, index_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  // Only the first three bytes need storage; the fourth lands straight in wdata.
  logic [23:0]         word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
  logic                error_q, error_d;
`endif

  logic                w_accept;
  logic [CNT_W-1:0]    w_index_inc;
  logic [ADDR_W-1:0]   w_offset;

  assign w_accept    = in_valid & in_ready;
  assign w_index_inc = index_q + CNT_W'(1);
  assign w_offset    = ADDR_W'({index_q, 2'b00});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      index_q    <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      index_q    <= index_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      error_q    <= error_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    index_d    = index_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    error_d    = error_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_d     = base_addr;
          count_d    = word_count;
          index_d    = '0;
          byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
          error_d    = 1'b0;
`endif
          state_d    = (word_count == '0) ? S_DONE : S_ASSEMBLE;
        end
      end
      S_ASSEMBLE: begin
        if (w_accept) begin
          word_d     = {word_q[15:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            addr_d  = base_q + w_offset;
            wdata_d = {word_q, in_data};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        index_d = w_index_inc;
        if (w_index_inc == count_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_ASSEMBLE;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_accept) begin
          error_d = (in_data != csum_q);
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  assign in_ready = (state_q == S_ASSEMBLE) || (state_q == S_CHECK);
  assign busy     = (state_q == S_ASSEMBLE) || (state_q == S_WRITE) || (state_q == S_CHECK);
  assign error    = error_q;
`else
  assign in_ready = (state_q == S_ASSEMBLE);
  assign busy     = (state_q == S_ASSEMBLE) || (state_q == S_WRITE);
  assign error    = 1'b0;
`endif

  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == S_DONE);
  // The core is released only by a clean completion.
  assign core_hold = !(done && !error);

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_mem_loader: directed stimulus against a queue-based model.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, busy, done, core_hold, error;
  logic [31:0] mem_addr, mem_wdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_we = 0;
  int          cyc = 0;
  int          last_we_cyc = -1;
  int          we_gap = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;
  bit          mon_en = 1'b0;
`ifdef LOADER_CHECKSUM_EN
  bit          csum_force_en = 1'b0;
  logic [7:0]  csum_force = '0;
`endif

  instr_mem_loader #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .busy       (busy),
    .done       (done),
    .core_hold  (core_hold),
    .error      (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_checks++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act_v, exp_v);
  endtask

  // Every write strobe must match the next word the model predicts.
  always @(negedge clk) begin
    if (mon_en) begin
      check("core_hold_rule", core_hold, !(done && !error));
      check("busy_done_excl", busy & done, 0);
      if (mem_we === 1'b1) begin
        n_we++;
        if (last_we_cyc >= 0) we_gap = cyc - last_we_cyc;
        last_we_cyc = cyc;
        last_addr   = mem_addr;
        last_data   = mem_wdata;
        if (exp_q.size() == 0) begin
          check("unexpected_we", mem_we, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", mem_addr, mon_e.addr);
          check("wr_data", mem_wdata, mon_e.data);
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  function automatic logic [7:0] xor_q(input logic [7:0] b[$]);
    logic [7:0] x = '0;
    foreach (b[i]) x ^= b[i];
    return x;
  endfunction
`endif

  task automatic do_start(input logic [31:0] base, input logic [15:0] cnt);
    base_addr  = base;
    word_count = cnt;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   t = 0;
    logic acc = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    check("byte_accepted", acc, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_core_hold", core_hold, 1);
    check("rst_error", error, 0);
  endtask

  // Model: word i is bytes 4i..4i+3 big-endian, at base + 4i modulo 2^32.
  task automatic run_load(input logic [31:0] base, input int nwords, input logic [7:0] b[$],
                          input bit gappy, input bit poke_start);
    wr_t e;
    for (int i = 0; i < nwords; i++) begin
      e.addr = base + (32'(i) << 2);
      e.data = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
      exp_q.push_back(e);
    end
    do_start(base, 16'(nwords));
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i]);
      if (gappy && (i % 4) == 1) begin
        if (poke_start) begin
          base_addr  = 32'h0;
          word_count = 16'h0;
          start      = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum_force_en ? csum_force : xor_q(b));
`endif
    wait_done();
    check("pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b1[$];
    logic [7:0] b5[$];
    logic [7:0] b6[$];
    int         nw;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    base_addr = '0; word_count = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_reset_vals();

    // Basic two-word load at base 500, continuous stream.
    b1 = '{8'h20, 8'h11, 8'h00, 8'h0A, 8'h20, 8'h12, 8'h00, 8'h14};
    run_load(32'd500, 2, b1, 1'b0, 1'b0);
    check("t1_core_hold", core_hold, 0);
    check("t1_error", error, 0);
    check("t1_busy", busy, 0);
    check("t1_last_addr", last_addr, 32'd504);
    check("t1_last_data", last_data, 32'h2012_0014);
    check("t1_word_gap", we_gap, 5);
    check("t1_addr_hold", mem_addr, 32'd504);

    // Same load with in_valid stalls mid-word and a start pulse that must be ignored.
    run_load(32'd500, 2, b1, 1'b1, 1'b1);
    check("t2_core_hold", core_hold, 0);
    check("t2_last_data", last_data, 32'h2012_0014);

    // Reset after two bytes of a word abandons it.
    nw = n_we;
    do_start(32'd100, 16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    in_data = 8'hCC; in_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_reset_vals();
    repeat (6) @(negedge clk);
    check("t4_no_write", n_we, nw);

    // Zero-length load completes on the next cycle.
    nw = n_we;
    do_start(32'h40, 16'd0);
    @(negedge clk);
    check("t3_done", done, 1);
    check("t3_core_hold", core_hold, 0);
    check("t3_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("t3_no_write", n_we, nw);

    // Address wrap-around at the top of the address space.
    b5 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    run_load(32'hFFFF_FFFC, 2, b5, 1'b0, 1'b0);
    check("t5_last_addr", last_addr, 32'h0000_0000);
    check("t5_last_data", last_data, 32'h0102_0304);
    check("t5_core_hold", core_hold, 0);

`ifdef LOADER_CHECKSUM_EN
    b6 = '{8'h01, 8'h02, 8'h03, 8'h04};
    csum_force_en = 1'b1;
    csum_force    = 8'h04;
    run_load(32'h1000, 1, b6, 1'b0, 1'b0);
    check("t6_good_error", error, 0);
    check("t6_good_core_hold", core_hold, 0);
    csum_force    = 8'h05;
    run_load(32'h1000, 1, b6, 1'b0, 1'b0);
    check("t6_bad_error", error, 1);
    check("t6_bad_done", done, 1);
    check("t6_bad_core_hold", core_hold, 1);
    csum_force_en = 1'b0;
`else
    b6 = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(32'h1000, 1, b6, 1'b0, 1'b0);
    check("t6_error_tied", error, 0);
    check("t6_last_data", last_data, 32'h0102_0304);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
